// File: rtl/pe_rr_scheduler.sv
// rtl/pe_rr_scheduler.sv - round-robin scheduler sharing one dot-product PE among requesters
module pe_rr_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int NoOfElem = 16,
    parameter int wordSize = 32,
    parameter int TIMEOUT  = 2 * NoOfElem + 4
) (
    input  logic                                      clk,
    input  logic                                      RESET,
    input  logic [NUM_REQ-1:0]                        req_valid,
    output logic [NUM_REQ-1:0]                        req_ready,
    input  logic [NUM_REQ-1:0][NoOfElem*wordSize-1:0] req_in1,
    input  logic [NUM_REQ-1:0][NoOfElem*wordSize-1:0] req_in2,
    output logic                                      resp_valid,
    input  logic                                      resp_ready,
    output logic [$clog2(NUM_REQ)-1:0]                resp_id,
    output logic [wordSize-1:0]                       resp_data,
    output logic                                      resp_err,
    output logic                                      busy,
    output logic                                      pe_rst_n,
    output logic [NoOfElem*wordSize-1:0]              pe_in1,
    output logic [NoOfElem*wordSize-1:0]              pe_in2,
    input  logic [wordSize-1:0]                       pe_out,
    input  logic                                      pe_valid
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] cand;
    logic           grant_found;
    logic [CW-1:0]  run_cnt;
    logic           timeout_hit;

    // Search upward from the RR pointer, wrapping at NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
            cand = (cand == IDW'(NUM_REQ - 1)) ? '0 : cand + IDW'(1);
        end
    end

    assign timeout_hit = (run_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_found) next_state = LOAD;
            LOAD:    next_state = RUN;
            RUN:     if (pe_valid || timeout_hit) next_state = RESP;
            RESP:    if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_found) req_ready[grant_id] = 1'b1;
    end

    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!RESET) begin
            state     <= IDLE;
            pe_rst_n  <= 1'b0;
            resp_id   <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
            pe_in1    <= '0;
            pe_in2    <= '0;
            rr_ptr    <= '0;
            run_cnt   <= '0;
        end else begin
            state    <= next_state;
            // Registered so the PE sees a clean release only while RUN is occupied.
            pe_rst_n <= (next_state == RUN);
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        pe_in1  <= req_in1[grant_id];
                        pe_in2  <= req_in2[grant_id];
                        resp_id <= grant_id;
                    end
                end
                LOAD: run_cnt <= '0;
                RUN: begin
                    run_cnt <= run_cnt + CW'(1);
                    if (pe_valid) begin
                        resp_data <= pe_out;
                        resp_err  <= 1'b0;
                    end else if (timeout_hit) begin
                        resp_data <= '0;
                        resp_err  <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready)
                        rr_ptr <= (resp_id == IDW'(NUM_REQ - 1)) ? '0 : resp_id + IDW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_rr_scheduler.sv
// tb/tb_pe_rr_scheduler.sv - self-checking bench for pe_rr_scheduler with a timeline model
module tb_pe_rr_scheduler;

    localparam int NR  = 4;
    localparam int N   = 16;
    localparam int W   = 32;
    localparam int TO  = 2 * N + 4;
    localparam int VW  = N * W;
    localparam int IDW = $clog2(NR);

    logic                   clk = 1'b0;
    logic                   RESET;
    logic [NR-1:0]          req_valid;
    logic [NR-1:0]          req_ready;
    logic [NR-1:0][VW-1:0]  req_in1;
    logic [NR-1:0][VW-1:0]  req_in2;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [IDW-1:0]         resp_id;
    logic [W-1:0]           resp_data;
    logic                   resp_err;
    logic                   busy;
    logic                   pe_rst_n;
    logic [VW-1:0]          pe_in1;
    logic [VW-1:0]          pe_in2;
    logic [W-1:0]           pe_out;
    logic                   pe_valid;

    always #5 clk = ~clk;

    pe_rr_scheduler #(.NUM_REQ(NR), .NoOfElem(N), .wordSize(W), .TIMEOUT(TO)) dut (
        .clk(clk), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in1(req_in1), .req_in2(req_in2),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
        .busy(busy), .pe_rst_n(pe_rst_n),
        .pe_in1(pe_in1), .pe_in2(pe_in2),
        .pe_out(pe_out), .pe_valid(pe_valid)
    );

    // PE: one element per cycle after release, sticky valid one cycle after the last element.
    int                  pidx;
    logic signed [W-1:0] pacc;
    logic                pvalid;
    bit                  pe_dead;
    always @(posedge clk) begin
        if (!pe_rst_n) begin
            pidx   <= 0;
            pacc   <= '0;
            pvalid <= 1'b0;
        end else if (pidx < N) begin
            pacc <= pacc + $signed(pe_in1[pidx*W +: W]) * $signed(pe_in2[pidx*W +: W]);
            pidx <= pidx + 1;
        end else if (!pe_dead) begin
            pvalid <= 1'b1;
        end
    end
    assign pe_out   = pacc;
    assign pe_valid = pvalid;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int dot(input logic [VW-1:0] a, input logic [VW-1:0] b);
        int s = 0;
        for (int k = 0; k < N; k++) s += $signed(a[k*W +: W]) * $signed(b[k*W +: W]);
        return s;
    endfunction

    // Model: job = (accept cycle, owner, expected result, latency); outputs follow from elapsed cycles.
    bit            chk_en = 1'b0;
    bit            m_busy = 1'b0;
    int            m_rr   = 0;
    int            m_acc  = 0;
    int            m_lat  = 0;
    int            m_id   = 0;
    int            m_data = 0;
    bit            m_err  = 1'b0;
    logic [VW-1:0] m_op1;
    logic [VW-1:0] m_op2;

    initial begin : compare
        int            k;
        int            win;
        int            c;
        logic [NR-1:0] exp_rdy;
        bit            exp_rv;
        bit            exp_rst;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                k       = cyc - m_acc;
                win     = -1;
                exp_rdy = '0;
                if (!m_busy) begin
                    for (int j = 0; j < NR; j++) begin
                        c = (m_rr + j) % NR;
                        if (win < 0 && req_valid[IDW'(c)]) win = c;
                    end
                end
                if (win >= 0) exp_rdy[IDW'(win)] = 1'b1;
                exp_rv  = m_busy && (k >= m_lat);
                exp_rst = m_busy && (k >= 2) && (k < m_lat);
                check("req_ready", req_ready, exp_rdy);
                check("busy", busy, m_busy);
                check("resp_valid", resp_valid, exp_rv);
                check("pe_rst_n", pe_rst_n, exp_rst);
                if (m_busy && k >= 1) begin
                    check("pe_in1", pe_in1 === m_op1, 1);
                    check("pe_in2", pe_in2 === m_op2, 1);
                end
                if (exp_rv) begin
                    check("resp_id", resp_id, m_id);
                    check("resp_data", resp_data, $unsigned(m_data));
                    check("resp_err", resp_err, m_err);
                end
                if (win >= 0) begin
                    m_busy = 1'b1;
                    m_acc  = cyc;
                    m_id   = win;
                    m_op1  = req_in1[IDW'(win)];
                    m_op2  = req_in2[IDW'(win)];
                    m_lat  = pe_dead ? TO + 2 : N + 4;
                    m_err  = pe_dead;
                    m_data = pe_dead ? 0 : dot(m_op1, m_op2);
                end else if (exp_rv && resp_ready) begin
                    m_busy = 1'b0;
                    m_rr   = (m_id + 1) % NR;
                end
                if (!RESET) begin
                    m_busy = 1'b0;
                    m_rr   = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int acc);
        acc = -1;
        for (int i = 0; i < 60 && acc < 0; i++) begin
            @(negedge clk);
            if ((req_valid & req_ready) != '0) acc = cyc;
        end
        check("grant_seen", acc >= 0, 1);
    endtask

    task automatic wait_resp(output int at);
        at = -1;
        for (int i = 0; i < 100 && at < 0; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) at = cyc;
        end
        check("resp_seen", at >= 0, 1);
    endtask

    int            acc;
    int            at;
    int            ids [5];
    logic [W-1:0]  held_data;

    initial begin
        RESET      = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b1;
        pe_dead    = 1'b0;
        req_in1    = '0;
        req_in2    = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_resp_id", resp_id, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_busy", busy, 0);
        check("rst_pe_rst_n", pe_rst_n, 0);
        check("rst_pe_in1", pe_in1, 0);
        tick();
        RESET  = 1'b1;
        chk_en = 1'b1;

        // Round-robin with all four requesters asserting
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < N; k++) begin
                req_in1[r][k*W +: W] = W'(r * 7 + k - 5);
                req_in2[r][k*W +: W] = W'((r + 1) * (k + 2) - 9);
            end
        tick();
        req_valid = '1;
        for (int n = 0; n < 5; n++) begin
            wait_resp(at);
            ids[n] = int'(resp_id);
        end
        tick();
        req_valid = '0;
        for (int n = 0; n < 5; n++) check("rr_order", ids[n], n % NR);

        // Single job on requester 2: sum of k for k=0..15 is 120
        for (int k = 0; k < N; k++) begin
            req_in1[2][k*W +: W] = W'(1);
            req_in2[2][k*W +: W] = W'(k);
        end
        tick();
        req_valid = 4'b0100;
        wait_grant(acc);
        check("single_grant", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        wait_resp(at);
        check("single_latency", at - acc, 20);
        check("single_id", resp_id, 2);
        check("single_data", resp_data, 120);
        check("single_err", resp_err, 0);

        // Backpressure: response held 10 extra cycles
        tick();
        resp_ready = 1'b0;
        req_valid  = 4'b0011;
        wait_grant(acc);
        wait_resp(at);
        check("bp_id", resp_id, 0);
        held_data = resp_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid_held", resp_valid, 1);
            check("bp_data_held", resp_data, held_data);
            check("bp_no_grant", req_ready, 0);
        end
        tick();
        resp_ready = 1'b1;
        req_valid  = '0;
        @(negedge clk);
        check("bp_handshake", resp_valid, 1);
        @(negedge clk);
        check("bp_idle_busy", busy, 0);
        check("bp_idle_valid", resp_valid, 0);

        // Timeout: PE never signals completion
        tick();
        pe_dead   = 1'b1;
        req_valid = 4'b1000;
        wait_grant(acc);
        tick();
        req_valid = '0;
        wait_resp(at);
        check("to_latency", at - acc, 38);
        check("to_id", resp_id, 3);
        check("to_err", resp_err, 1);
        check("to_data", resp_data, 0);
        tick();
        pe_dead = 1'b0;

        // Reset during the 5th RUN cycle abandons the job
        req_valid = 4'b0010;
        wait_grant(acc);
        check("mr_grant", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        repeat (5) @(posedge clk);
        #1;
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        @(negedge clk);
        check("mr_busy", busy, 0);
        check("mr_pe_rst_n", pe_rst_n, 0);
        check("mr_resp_valid", resp_valid, 0);
        check("mr_resp_id", resp_id, 0);
        repeat (40) @(negedge clk);
        tick();
        req_valid = 4'b1001;
        wait_grant(acc);
        check("mr_rr_restart", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        wait_resp(at);
        check("mr_next_latency", at - acc, 20);
        check("mr_next_id", resp_id, 0);
        check("mr_next_data", resp_data, $unsigned(dot(req_in1[0], req_in2[0])));

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, %0d failed so far", fails);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pe_rr_scheduler.md
Name: pe_rr_scheduler

Overview:
- Shares one dot-product PE (NoOfElem-element MAC engine with active-low restart and a sticky `valid`) among NUM_REQ requesters using round-robin arbitration.
- Per job it accepts one operand-vector pair from the winning requester and latches it into internal registers.
- It then restarts the PE through its reset pin, waits for the PE's `valid`, and returns the result on a single tagged response channel with a valid/ready handshake.
- Sits between the requester ports (vector lanes or DMA front-ends) and the PE instance.

Parameters:
- NUM_REQ, 4: number of requesters; must be ≥ 2.
- NoOfElem, 16: elements per operand vector; must match the PE.
- wordSize, 32: element and result width; must match the PE.
- TIMEOUT, 2*NoOfElem+4: maximum RUN cycles to wait for `pe_valid` before flagging an error.

Ports:
- `clk`  in  1  clock.
- `RESET`  in  1  synchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester job request.
- `req_ready`  out  NUM_REQ  one-hot grant/accept; a transfer occurs when `req_valid[i]` and `req_ready[i]` are both high.
- `req_in1`  in  NUM_REQ x NoOfElem x wordSize  packed operand vector 1, one per requester.
- `req_in2`  in  NUM_REQ x NoOfElem x wordSize  packed operand vector 2, one per requester.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_id`  out  $clog2(NUM_REQ)  index of the requester that owns the result.
- `resp_data`  out  wordSize  signed PE result.
- `resp_err`  out  1  job timed out; `resp_data` = 0.
- `busy`  out  1  high in any state other than IDLE.
- `pe_rst_n`  out  1  registered active-low restart to the PE.
- `pe_in1`, `pe_in2`  out  NoOfElem x wordSize  latched operands to the PE.
- `pe_out`  in  wordSize  PE result.
- `pe_valid`  in  1  PE done.

Behaviour:
- **Reset** (`RESET` = 0 at a `clk` edge; synchronous, active-low):
  - state → IDLE.
  - `pe_rst_n`=0, `req_ready`=0, `resp_valid`=0, `resp_err`=0, `resp_id`=0, `resp_data`=0, `busy`=0.
  - Operand registers → 0; RR pointer → 0; run counter → 0.
  - Reset mid-job abandons the job silently with no response.
- **IDLE** (`pe_rst_n`=0):
  - If any `req_valid`, the winner is the first set bit searching from the RR pointer upward, wrapping modulo NUM_REQ.
  - `req_ready[winner]`=1 combinationally in the same cycle; all other bits are 0.
  - On that edge: latch `req_in1`/`req_in2[winner]` and the winner id, then go to LOAD.
  - `req_ready` is 0 in every other state.
- **LOAD** (`pe_rst_n` stays 0, one cycle): operands are stable on `pe_in*` before the PE is released. Go to RUN and clear the run counter.
- **RUN**:
  - `pe_rst_n`=1 (registered transition, glitch-free); the run counter increments every cycle.
  - If `pe_valid`=1: capture `pe_out` into `resp_data`, set `resp_err`=0, go to RESP.
  - Else if counter = TIMEOUT-1: `resp_data`=0, `resp_err`=1, go to RESP.
  - `pe_valid` has priority if both conditions occur in the same cycle.
- **RESP**:
  - `resp_valid`=1; `resp_id`/`resp_data`/`resp_err` are held stable.
  - `pe_rst_n` returns to 0 on entry, so the PE is idled.
  - On `resp_valid` & `resp_ready`: RR pointer ← (id+1) mod NUM_REQ, go to IDLE.
  - `resp_ready` already high on the first RESP cycle completes in one cycle.
- **Latency** (nominal PE): `pe_valid` is seen in RUN cycle NoOfElem+1. `resp_valid` rises NoOfElem+4 cycles after the accept edge (20 for the defaults).
- **Throughput**: one job in flight. The next grant is possible in the cycle after the response handshake.
- **Ignored inputs**: `pe_valid` outside RUN is ignored; `pe_out` is not modified (no extension or saturation).
- **Requester withdrawal**: a requester dropping `req_valid` before being granted is never served.
- **Fairness**: with all requesters continuously asserting, grants follow 0,1,2,…,NUM_REQ-1,0,…

Test Plan:
- **Reset values**: hold `RESET`=0 for 3 cycles → all outputs at reset values, `pe_rst_n`=0, `busy`=0.
- **Single job**:
  - Stimulus: `req_valid`=4'b0100, in1 = all 1s, in2 = element k = k, PE model attached, `resp_ready`=1.
  - Response: `req_ready`=4'b0100 for exactly one cycle; `resp_valid` at accept+20; `resp_id`=2; `resp_data`=120; `resp_err`=0.
- **Round-robin**: all four requesters assert continuously → `resp_id` sequence 0,1,2,3,0; each response's data matches its requester's operands.
- **Backpressure**: hold `resp_ready`=0 for 10 cycles after `resp_valid` → outputs stable, no new `req_ready`; release → one handshake, then IDLE.
- **Timeout**: PE model never asserts `pe_valid` → `resp_valid` with `resp_err`=1 and `resp_data`=0 at accept+2+TIMEOUT (38 for the defaults).
- **Reset mid-RUN**: assert `RESET` for 1 cycle in the 5th RUN cycle → no response emitted; reset values restored; RR pointer 0; next request served normally.
